// File: rtl/psum_norm.sv
// Output normaliser for the core's psum bus: latches one psum vector, sums the
// magnitudes, then divides every element by that sum with one shared serial divider.
module psum_norm #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int bw_out  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw_psum*col-1:0] psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bw_out*col-1:0]  norm_out,
  output logic                   busy
);

  localparam int SW = bw_psum + $clog2(col);
  localparam int IW = (col > 1) ? $clog2(col) : 1;
  localparam int CW = (bw_out > 1) ? $clog2(bw_out) : 1;
  localparam int DW = bw_psum + bw_out;
  localparam logic [IW-1:0]       LastIdx = IW'(col - 1);
  localparam logic [CW-1:0]       LastBit = CW'(bw_out - 1);
  localparam logic [bw_out-2:0]   MaxMag  = '1;

  typedef enum logic [1:0] {IDLE, SUM, DIV, OUT} state_e;

  state_e                 state_q;
  logic [bw_psum*col-1:0] psum_q;
  logic [SW-1:0]          sum_q;
  logic [IW-1:0]          idx_q;
  logic [CW-1:0]          bitCnt_q;
  logic [SW-1:0]          rem_q;
  logic [bw_out-1:0]      lo_q;
  logic [bw_out*col-1:0]  norm_q;

  // One extra bit keeps the magnitude of the most negative psum exact.
  function automatic logic [bw_psum:0] absVal(input logic [bw_psum-1:0] x);
    logic [bw_psum:0] ext;
    ext = {x[bw_psum-1], x};
    return x[bw_psum-1] ? (~ext + (bw_psum+1)'(1)) : ext;
  endfunction

  logic [SW-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int q = 0; q < col; q++) begin
      sum_d = sum_d + SW'(absVal(psum_q[q*bw_psum +: bw_psum]));
    end
  end

  logic [bw_psum-1:0] elem;
  logic               elemNeg;
  logic [bw_psum:0]   elemAbs;
  logic [DW-1:0]      dividend;
  logic [SW-1:0]      remIn;
  logic [bw_out-1:0]  loIn;
  logic [SW:0]        trial;
  logic               qBit;
  logic [SW-1:0]      rem_d;
  logic [bw_out-1:0]  lo_d;
  logic [bw_out-2:0]  mag;
  logic [bw_out-1:0]  elem_d;

  // The first bit of each element starts from a fresh dividend so that no cycle
  // is spent loading it; the low register doubles as the quotient shift register.
  always_comb begin
    elem     = psum_q[idx_q*bw_psum +: bw_psum];
    elemNeg  = elem[bw_psum-1];
    elemAbs  = absVal(elem);
    dividend = {elemAbs, {(bw_out-1){1'b0}}};
    remIn    = (bitCnt_q == '0) ? SW'(dividend[DW-1:bw_out]) : rem_q;
    loIn     = (bitCnt_q == '0) ? dividend[bw_out-1:0] : lo_q;
    trial    = {remIn, loIn[bw_out-1]};
    qBit     = (trial >= {1'b0, sum_q});
    rem_d    = qBit ? SW'(trial - {1'b0, sum_q}) : trial[SW-1:0];
    lo_d     = {loIn[bw_out-2:0], qBit};
    mag      = (lo_d > {1'b0, MaxMag}) ? MaxMag : lo_d[bw_out-2:0];
    elem_d   = elemNeg ? (~{1'b0, mag} + bw_out'(1)) : {1'b0, mag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      psum_q   <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      bitCnt_q <= '0;
      rem_q    <= '0;
      lo_q     <= '0;
      norm_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            psum_q  <= psum_in;
            state_q <= SUM;
          end
        end
        SUM: begin
          sum_q    <= sum_d;
          idx_q    <= '0;
          bitCnt_q <= '0;
          if (sum_d == '0) begin
            norm_q  <= '0;
            state_q <= OUT;
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          lo_q  <= lo_d;
          if (bitCnt_q == LastBit) begin
            norm_q[idx_q*bw_out +: bw_out] <= elem_d;
            bitCnt_q <= '0;
            if (idx_q == LastIdx) begin
              state_q <= OUT;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            bitCnt_q <= bitCnt_q + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == SUM) || (state_q == DIV);
  assign norm_out  = norm_q;

endmodule

// File: tb/tb_psum_norm.sv
// Bench for psum_norm: directed cases with hand-derived results plus random
// vectors checked against an arithmetic reference of sign*floor(|x|*2^(bw_out-1)/S).
module tb_psum_norm;

  localparam int COL = 8;
  localparam int BP  = 20;
  localparam int BO  = 8;
  localparam int PW  = COL * BP;
  localparam int NW  = COL * BO;
  localparam int FULL_LAT = 1 + COL * BO;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] psum_in;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] norm_out;
  logic          busy;

  int passCnt  = 0;
  int totalCnt = 0;

  psum_norm #(.col(COL), .bw_psum(BP), .bw_out(BO)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .psum_in  (psum_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .norm_out (norm_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [BP-1:0] elemBits(input int v);
    return v[BP-1:0];
  endfunction

  function automatic logic [PW-1:0] fillVec(input int v);
    logic [PW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BP +: BP] = elemBits(v);
    return r;
  endfunction

  function automatic logic [NW-1:0] fillOut(input logic [BO-1:0] v);
    logic [NW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BO +: BO] = v;
    return r;
  endfunction

  // Reference: plain integer arithmetic on the whole vector.
  function automatic logic [NW-1:0] refNorm(input logic [PW-1:0] v);
    longint mags[COL];
    bit     negs[COL];
    longint s, q, x;
    logic [63:0]   qv;
    logic [BP-1:0] e;
    logic [NW-1:0] r;
    s = 0;
    for (int i = 0; i < COL; i++) begin
      e = v[i*BP +: BP];
      x = longint'($signed(e));
      negs[i] = (x < 0);
      mags[i] = (x < 0) ? -x : x;
      s += mags[i];
    end
    for (int i = 0; i < COL; i++) begin
      q = (s == 0) ? 0 : (mags[i] * (longint'(1) << (BO - 1))) / s;
      if (q > (longint'(1) << (BO - 1)) - 1) q = (longint'(1) << (BO - 1)) - 1;
      if (negs[i]) q = -q;
      qv = q;
      r[i*BO +: BO] = qv[BO-1:0];
    end
    return r;
  endfunction

  function automatic int refLatency(input logic [PW-1:0] v);
    return (v == '0) ? 1 : FULL_LAT;
  endfunction

  // Drives one vector from a negedge and returns at the negedge where out_valid is first seen.
  task automatic applyStimulus(input logic [PW-1:0] vec, output int lat,
                               output int busyCnt, output int readyLeak);
    lat = -1;
    busyCnt = 0;
    readyLeak = 0;
    for (int w = 0; w < 200 && !in_ready; w++) @(negedge clk);
    in_valid = 1'b1;
    psum_in  = vec;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    psum_in  = {5{$urandom()}};
    for (int n = 0; n <= 300; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      if (busy) busyCnt++;
      if (in_ready) readyLeak++;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    psum_in = '0;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    else passCnt++;
    totalCnt++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passCnt++;
    totalCnt++;
    if (norm_out !== '0) $display("[TB] FAIL reset_norm_out: got %h expected 0", norm_out);
    else passCnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_uniform();
    int lat, bc, leak;
    logic [NW-1:0] exp;
    exp = fillOut(8'd16);
    applyStimulus(fillVec(100), lat, bc, leak);
    totalCnt++;
    if (lat !== FULL_LAT) $display("[TB] FAIL uniform_latency: got %0d expected %0d", lat, FULL_LAT);
    else passCnt++;
    totalCnt++;
    if (bc !== FULL_LAT) $display("[TB] FAIL uniform_busy_cycles: got %0d expected %0d", bc, FULL_LAT);
    else passCnt++;
    totalCnt++;
    if (leak !== 0) $display("[TB] FAIL uniform_in_ready_while_busy: got %0d expected 0", leak);
    else passCnt++;
    totalCnt++;
    if (norm_out !== exp) $display("[TB] FAIL uniform_result: got %h expected %h", norm_out, exp);
    else passCnt++;
    ack();
    totalCnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL uniform_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    else passCnt++;
  endtask

  task automatic test_saturation();
    int lat, bc, leak;
    logic [PW-1:0] vec;
    logic [NW-1:0] exp;
    vec = '0;
    vec[3*BP +: BP] = elemBits(500);
    exp = '0;
    exp[3*BO +: BO] = 8'd127;
    applyStimulus(vec, lat, bc, leak);
    totalCnt++;
    if (norm_out !== exp) $display("[TB] FAIL saturation_result: got %h expected %h", norm_out, exp);
    else passCnt++;
    ack();
  endtask

  task automatic test_mixed_sign();
    int lat, bc, leak;
    logic [PW-1:0] vec;
    logic [NW-1:0] exp;
    vec = '0;
    vec[0*BP +: BP] = elemBits(-300);
    vec[1*BP +: BP] = elemBits(100);
    exp = '0;
    exp[0*BO +: BO] = 8'hA0;
    exp[1*BO +: BO] = 8'd32;
    applyStimulus(vec, lat, bc, leak);
    totalCnt++;
    if (norm_out !== exp) $display("[TB] FAIL mixed_sign_result: got %h expected %h", norm_out, exp);
    else passCnt++;
    ack();
  endtask

  task automatic test_extremes();
    int lat, bc, leak;
    logic [NW-1:0] exp;
    exp = fillOut(8'hF0);
    applyStimulus(fillVec(-524288), lat, bc, leak);
    totalCnt++;
    if (norm_out !== exp) $display("[TB] FAIL extremes_result: got %h expected %h", norm_out, exp);
    else passCnt++;
    totalCnt++;
    if (lat !== FULL_LAT) $display("[TB] FAIL extremes_latency: got %0d expected %0d", lat, FULL_LAT);
    else passCnt++;
    ack();
  endtask

  task automatic test_zero();
    int lat, bc, leak;
    applyStimulus('0, lat, bc, leak);
    totalCnt++;
    if (lat !== 1) $display("[TB] FAIL zero_latency: got %0d expected 1", lat);
    else passCnt++;
    totalCnt++;
    if (bc !== 1) $display("[TB] FAIL zero_busy_cycles: got %0d expected 1", bc);
    else passCnt++;
    totalCnt++;
    if (norm_out !== '0) $display("[TB] FAIL zero_result: got %h expected 0", norm_out);
    else passCnt++;
    ack();
  endtask

  task automatic test_handshake_hold();
    int lat, bc, leak;
    logic [PW-1:0] vec;
    logic [NW-1:0] exp;
    for (int i = 0; i < COL; i++) vec[i*BP +: BP] = elemBits((i % 2 == 0) ? 50 * (i + 1) : -50 * (i + 1));
    exp = refNorm(vec);
    applyStimulus(vec, lat, bc, leak);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      psum_in  = fillVec(7);
      @(posedge clk);
      @(negedge clk);
      totalCnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL hold_flags cycle %0d: got out_valid=%b in_ready=%b busy=%b expected 1/0/0",
                 c, out_valid, in_ready, busy);
      else passCnt++;
      totalCnt++;
      if (norm_out !== exp) $display("[TB] FAIL hold_result cycle %0d: got %h expected %h", c, norm_out, exp);
      else passCnt++;
    end
    in_valid = 1'b0;
    ack();
    totalCnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL hold_release: got out_valid=%b in_ready=%b busy=%b expected 0/1/0",
               out_valid, in_ready, busy);
    else passCnt++;
    totalCnt++;
    if (norm_out !== exp) $display("[TB] FAIL hold_idle_retain: got %h expected %h", norm_out, exp);
    else passCnt++;
  endtask

  task automatic test_reset_mid_div();
    int lat, bc, leak;
    logic [PW-1:0] vec;
    in_valid = 1'b1;
    psum_in  = fillVec(100);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (21) @(negedge clk);
    totalCnt++;
    if (busy !== 1'b1) $display("[TB] FAIL middiv_busy: got %b expected 1", busy);
    else passCnt++;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    totalCnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL middiv_reset_state: got in_ready=%b out_valid=%b busy=%b expected 1/0/0",
               in_ready, out_valid, busy);
    else passCnt++;
    totalCnt++;
    if (norm_out !== '0) $display("[TB] FAIL middiv_reset_norm: got %h expected 0", norm_out);
    else passCnt++;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL middiv_stays_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    else passCnt++;
    vec = '0;
    vec[2*BP +: BP] = elemBits(-1000);
    vec[5*BP +: BP] = elemBits(3000);
    vec[7*BP +: BP] = elemBits(1);
    applyStimulus(vec, lat, bc, leak);
    totalCnt++;
    if (norm_out !== refNorm(vec)) $display("[TB] FAIL middiv_next_result: got %h expected %h", norm_out, refNorm(vec));
    else passCnt++;
    totalCnt++;
    if (lat !== FULL_LAT) $display("[TB] FAIL middiv_next_latency: got %0d expected %0d", lat, FULL_LAT);
    else passCnt++;
    ack();
  endtask

  task automatic test_random();
    int lat, bc, leak, kind, v;
    logic [PW-1:0] vec;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < COL; i++) begin
        kind = int'($urandom_range(0, 3));
        case (kind)
          0: v = 0;
          1: v = int'($urandom_range(0, 2000)) - 1000;
          2: v = int'($urandom_range(0, 1048575)) - 524288;
          default: v = ($urandom_range(0, 1) == 1) ? -524288 : 524287;
        endcase
        if (n == 0) v = 0;
        vec[i*BP +: BP] = elemBits(v);
      end
      applyStimulus(vec, lat, bc, leak);
      totalCnt++;
      if (norm_out !== refNorm(vec))
        $display("[TB] FAIL random_result #%0d: got %h expected %h", n, norm_out, refNorm(vec));
      else passCnt++;
      totalCnt++;
      if (lat !== refLatency(vec))
        $display("[TB] FAIL random_latency #%0d: got %0d expected %0d", n, lat, refLatency(vec));
      else passCnt++;
      ack();
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, leak;
    logic [PW-1:0] vec;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < COL; i++) vec[i*BP +: BP] = elemBits(int'($urandom_range(0, 4000)) - 2000);
      applyStimulus(vec, lat, bc, leak);
      totalCnt++;
      if (norm_out !== refNorm(vec))
        $display("[TB] FAIL b2b_result #%0d: got %h expected %h", n, norm_out, refNorm(vec));
      else passCnt++;
      ack();
      totalCnt++;
      if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_after_ack #%0d: got %b expected 1", n, in_ready);
      else passCnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    psum_in = '0;
    $display("[TB] psum_norm bench start");
    test_reset();
    test_uniform();
    test_saturation();
    test_mixed_sign();
    test_extremes();
    test_zero();
    test_handshake_hold();
    test_reset_mid_div();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/psum_norm.md
Name: psum_norm

Overview:
- Output stage directly downstream of the core's psum output bus (col signed psums of bw_psum bits each).
- Latches one psum vector and computes S = sum of |psum[q]|.
- Normalises each element to a signed fixed-point fraction psum[q]/S using a shared serial restoring divider.
- Presents the normalised vector with a valid/ready handshake to the next consumer (output SRAM / host readout).

Parameters:
- col, 8, number of psum elements per vector.
- bw_psum, 20, width of each signed input psum.
- bw_out, 8, width of each signed normalised output; output is Q1.(bw_out-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  psum_in holds a vector to be accepted.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- psum_in  input  bw_psum*col  element q at [q*bw_psum +: bw_psum], two's complement.
- out_valid  output  1  norm_out holds a complete result; high only in OUT.
- out_ready  input  1  consumer accepts norm_out.
- norm_out  output  bw_out*col  element q at [q*bw_out +: bw_out], two's complement.
- busy  output  1  high in SUM or DIV.

Behaviour:
- Reset: state=IDLE; in_ready=1 (combinational from IDLE); out_valid=0; busy=0; norm_out=0; all internal registers cleared. Reset asserted in any state (including mid-DIV or OUT with out_ready low) aborts the operation, discards the partial result and wins over every handshake in that cycle.
- Sum register width: bw_psum+clog2(col) = 23 bits, unsigned. |x| uses a bw_psum+1-bit intermediate, so |-2^19| = 2^19 exactly with no overflow.
- States:
  - IDLE: in_ready=1. When in_valid=1, the edge latches psum_in and goes to SUM.
  - SUM: one cycle. The edge loads S from a combinational adder tree over the latched vector. If S==0, the same edge sets norm_out=0 and goes to OUT. Otherwise it clears the element index and goes to DIV.
  - DIV: elements processed in order q=0..col-1.
    - Per element: dividend = |psum[q]| << (bw_out-1); divisor = S.
    - Restoring division produces one quotient bit per cycle, MSB first, over bw_out cycles.
    - Quotient Q is unsigned, 0 <= Q <= 2^(bw_out-1).
    - Result: saturate Q to 2^(bw_out-1)-1, apply the element's sign (negate if negative), and write it into norm_out slice q on that element's last edge.
    - After element col-1, go to OUT.
    - DIV lasts exactly col*bw_out cycles. Default: 64.
  - OUT: out_valid=1 and norm_out is stable. When out_ready=1, the edge goes to IDLE and out_valid falls.
- norm_out slices may update during DIV but are only valid while out_valid=1. norm_out holds its value in IDLE until the next result overwrites it.
- Latency, counted from the accepting edge to the edge that raises out_valid:
  - 1 + col*bw_out edges (default 65).
  - 1 edge when S==0.
- Throughput: one vector per (latency + 1 + handshake wait) cycles. No overlap or bypass: in_ready=0 in SUM, DIV and OUT, including the OUT cycle in which out_ready=1.
- in_valid is ignored outside IDLE. psum_in may change freely after acceptance.
- Rounding: truncation toward zero on magnitude, so output = sign * floor(|x|*2^(bw_out-1)/S).
- Invariant: |norm_out[q]| <= 2^(bw_out-1)-1. The most negative code -2^(bw_out-1) is never produced.

Test Plan:
- Uniform positive: all 8 psums = 100 (S=800) -> every element = floor(12800/800) = 16. out_valid rises 65 edges after the accept edge.
- Single dominant / saturation: psum[3]=500, others 0 -> element 3 = 127 (Q=128 saturated), all others 0.
- Mixed sign: psum[0]=-300, psum[1]=100, others 0 (S=400) -> element 0 = -96 (0xA0), element 1 = 32, rest 0.
- Extremes: all psums = -524288 (S=2^22, no sum overflow) -> every element = -16.
- Zero vector: all psums 0 -> norm_out = 0 and out_valid high 1 edge after accept. No divide activity; busy high for exactly 1 cycle.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in OUT -> out_valid and norm_out stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next edge.
  - Separately, assert reset 20 cycles into DIV -> next edge IDLE, out_valid=0, norm_out=0. A following vector is processed correctly.
